// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared sizes, flow ops, state encoding and instruction field helpers
package cpu_ctrl_pkg;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 4;
    localparam int CNTW  = 8;
    localparam int IW    = 9;

    localparam logic [1:0] FLOW_NEXT = 2'b00;
    localparam logic [1:0] FLOW_JMP  = 2'b01;
    localparam logic [1:0] FLOW_JC   = 2'b10;
    localparam logic [1:0] FLOW_HALT = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam int FLOW_LSB = 7;
    localparam int TGT_LSB  = 4;
    localparam int CTRL_LSB = 0;

    localparam int CTRL_LOAD = 0;
    localparam int CTRL_MUX  = 1;
    localparam int CTRL_ALU  = 2;

    function automatic logic [1:0] ins_flow(input logic [IW-1:0] i);
        return i[FLOW_LSB +: 2];
    endfunction

    function automatic logic [AW-1:0] ins_target(input logic [IW-1:0] i);
        return i[TGT_LSB +: AW];
    endfunction

    function automatic logic [CW-1:0] ins_ctrl(input logic [IW-1:0] i);
        return i[CTRL_LSB +: CW];
    endfunction
endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: control/programming bus between a host and the sequencer
interface cpu_sequencer_if;
    import cpu_ctrl_pkg::*;
    logic            start;
    logic            step;
    logic            halt_req;
    logic            prog_we;
    logic [AW-1:0]   prog_addr;
    logic [IW-1:0]   prog_data;
    logic            carry_in;
    logic [CW-1:0]   ctrl_out;
    logic [AW-1:0]   pc_out;
    logic [1:0]      state_out;
    logic            busy;
    logic            prog_err;
    logic [CNTW-1:0] exec_cnt;

    modport master (
        output start, step, halt_req, prog_we, prog_addr, prog_data, carry_in,
        input  ctrl_out, pc_out, state_out, busy, prog_err, exec_cnt
    );

    modport slave (
        input  start, step, halt_req, prog_we, prog_addr, prog_data, carry_in,
        output ctrl_out, pc_out, state_out, busy, prog_err, exec_cnt
    );
endinterface

// File: rtl/seq_prog_mem.sv
// seq_prog_mem: flop-based microprogram store, one write port, one async read port
module seq_prog_mem
    import cpu_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);
    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] mem_d [DEPTH];

    assign rdata = mem_q[raddr];

    // merge the single write into the next-state copy of the store
    always_comb begin
        mem_d = mem_q;
        if (we) mem_d[waddr] = wdata;
    end

    // store clears to all-NEXT/ctrl-0 on reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) mem_q <= '{default: '0};
        else       mem_q <= mem_d;
    end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: programmable run/halt/step microsequencer driving the datapath control word
module cpu_sequencer
    import cpu_ctrl_pkg::*;
(
    input logic            clk,
    input logic            rstn,
    cpu_sequencer_if.slave bus
);
    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [IW-1:0]   instr;
    logic [1:0]      flow;
    logic            issuing;

    assign issuing = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign flow    = ins_flow(instr);

    seq_prog_mem u_mem (
        .clk   (clk),
        .rstn  (rstn),
        .we    (bus.prog_we && !issuing),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc_q),
        .rdata (instr)
    );

    assign bus.ctrl_out  = issuing ? ins_ctrl(instr) : '0;
    assign bus.pc_out    = pc_q;
    assign bus.state_out = state_q;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.prog_err  = err_q;
    assign bus.exec_cnt  = cnt_q;

    // sequencing: execute current instruction while issuing, otherwise accept start/step
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (issuing) begin
            pc_d    = (flow == FLOW_JMP || (flow == FLOW_JC && bus.carry_in)) ? ins_target(instr) : pc_q + AW'(1);
            state_d = (state_q == ST_STEP || flow == FLOW_HALT || bus.halt_req) ? ST_HALTED : ST_RUN;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNTW'(1);
            err_d   = err_q | bus.prog_we;
        end else if (!bus.halt_req && bus.start) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (!bus.halt_req && bus.step) begin
            state_d = ST_STEP;
        end
    end

    // architectural state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and random checks of cpu_sequencer against a behavioural model
module tb_cpu_sequencer;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    cpu_sequencer_if bus();

    cpu_sequencer dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [8:0] m [8];
    int mst, mpc, mcnt;
    bit merr;

    function automatic logic [8:0] ins(input int f, input int t, input int c);
        logic [8:0] r;
        r = {f[1:0], t[2:0], c[3:0]};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int ec;
        ec = (mst == 1 || mst == 2) ? int'(m[mpc][3:0]) : 0;
        chk("ctrl_out", bus.ctrl_out, ec);
        chk("pc_out", bus.pc_out, mpc);
        chk("state_out", bus.state_out, mst);
        chk("busy", bus.busy, mst == 1);
        chk("prog_err", bus.prog_err, merr);
        chk("exec_cnt", bus.exec_cnt, mcnt);
    endtask

    task automatic model_reset();
        mst = 0; mpc = 0; mcnt = 0; merr = 0;
        for (int i = 0; i < 8; i++) m[i] = '0;
    endtask

    task automatic cyc();
        int nst, npc, ncnt, f, t;
        bit nerr;
        #1 check_all();
        nst = mst; npc = mpc; ncnt = mcnt; nerr = merr;
        if (mst == 1 || mst == 2) begin
            f = int'(m[mpc][8:7]);
            t = int'(m[mpc][6:4]);
            npc  = (f == 1 || (f == 2 && bus.carry_in)) ? t : (mpc + 1) % 8;
            nst  = (mst == 2 || f == 3 || bus.halt_req) ? 3 : 1;
            ncnt = (mcnt < 255) ? mcnt + 1 : 255;
            nerr = merr | bus.prog_we;
        end else begin
            if (bus.prog_we) m[bus.prog_addr] = bus.prog_data;
            if (!bus.halt_req && bus.start) begin
                nst = 1; ncnt = 0; nerr = 0;
            end else if (!bus.halt_req && bus.step) begin
                nst = 2;
            end
        end
        @(posedge clk);
        mst = nst; mpc = npc; mcnt = ncnt; merr = nerr;
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.start = 0; bus.step = 0; bus.halt_req = 0; bus.prog_we = 0;
        bus.prog_addr = '0; bus.prog_data = '0; bus.carry_in = 0;
    endtask

    task automatic do_reset();
        rstn = 0;
        #1 model_reset();
        check_all();
        #1 rstn = 1;
    endtask

    task automatic wr(input int a, input logic [8:0] d);
        bus.prog_we = 1; bus.prog_addr = a[2:0]; bus.prog_data = d;
        cyc();
        bus.prog_we = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1; cyc(); bus.start = 0;
    endtask

    task automatic jc_run(input bit c, input int exp_pc);
        do_reset();
        wr(0, ins(2, 5, 4));
        wr(5, ins(3, 0, 0));
        wr(1, ins(3, 0, 0));
        bus.carry_in = c;
        pulse_start();
        chk("t3_jc_ctrl", bus.ctrl_out, 4);
        cyc();
        bus.carry_in = 0;
        chk("t3_jc_pc", bus.pc_out, exp_pc);
        cyc();
        chk("t3_halted", bus.state_out, 3);
    endtask

    initial begin
        idle_in();
        @(negedge clk);
        do_reset();
        chk("reset_state", bus.state_out, 0);

        wr(0, ins(0, 0, 1));
        wr(1, ins(0, 0, 5));
        wr(2, ins(3, 0, 0));
        pulse_start();
        chk("t1_c0", bus.ctrl_out, 1);
        cyc();
        chk("t1_c1", bus.ctrl_out, 5);
        cyc();
        chk("t1_c2", bus.ctrl_out, 0);
        chk("t1_run", bus.state_out, 1);
        cyc();
        chk("t1_halted", bus.state_out, 3);
        chk("t1_pc", bus.pc_out, 3);
        chk("t1_cnt", bus.exec_cnt, 3);
        chk("t1_ctrl_off", bus.ctrl_out, 0);

        wr(7, ins(0, 0, 2));
        wr(0, ins(3, 0, 0));
        wr(6, ins(1, 7, 3));
        pulse_start();
        repeat (3) cyc();
        chk("t2_pc6", bus.pc_out, 6);
        cyc();
        chk("t2_pc7", bus.pc_out, 7);
        chk("t2_ctrl7", bus.ctrl_out, 2);
        cyc();
        chk("t2_wrap", bus.pc_out, 0);
        cyc();
        chk("t2_halted", bus.state_out, 3);
        chk("t2_pc", bus.pc_out, 1);
        chk("t2_cnt", bus.exec_cnt, 6);

        jc_run(1, 5);
        jc_run(0, 1);

        do_reset();
        for (int i = 0; i < 8; i++) wr(i, ins(0, 0, i + 8));
        pulse_start();
        repeat (3) cyc();
        bus.halt_req = 1; cyc(); bus.halt_req = 0;
        chk("t4_halted", bus.state_out, 3);
        chk("t4_cnt", bus.exec_cnt, 4);
        chk("t4_pc", bus.pc_out, 4);
        bus.step = 1; cyc(); bus.step = 0;
        chk("t4_step_state", bus.state_out, 2);
        chk("t4_step_ctrl", bus.ctrl_out, 12);
        cyc();
        chk("t4_after_step", bus.state_out, 3);
        chk("t4_step_cnt", bus.exec_cnt, 5);
        chk("t4_step_ctrl_off", bus.ctrl_out, 0);

        do_reset();
        pulse_start();
        cyc();
        bus.prog_we = 1; bus.prog_addr = 3'd5; bus.prog_data = ins(3, 0, 15);
        cyc();
        bus.prog_we = 0;
        chk("t5_err_set", bus.prog_err, 1);
        bus.halt_req = 1; cyc(); bus.halt_req = 0;
        chk("t5_err_sticky", bus.prog_err, 1);
        pulse_start();
        chk("t5_err_clr", bus.prog_err, 0);
        repeat (2) cyc();
        chk("t5_pc5", bus.pc_out, 5);
        chk("t5_entry_kept", bus.ctrl_out, 0);
        cyc();
        chk("t5_still_run", bus.state_out, 1);

        bus.halt_req = 1; cyc(); bus.halt_req = 0;
        wr(4, ins(0, 0, 9));
        pulse_start();
        repeat (2) cyc();
        do_reset();
        chk("t6_ctrl0", bus.ctrl_out, 0);
        chk("t6_idle", bus.state_out, 0);
        bus.start = 1; bus.halt_req = 1; cyc(); bus.start = 0; bus.halt_req = 0;
        chk("t6_halt_prio", bus.state_out, 0);
        pulse_start();
        repeat (300) cyc();
        chk("t6_sat", bus.exec_cnt, 255);
        bus.halt_req = 1; cyc(); bus.halt_req = 0;
        chk("t6_sat_halt", bus.state_out, 3);
        chk("t6_sat_hold", bus.exec_cnt, 255);

        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 0) do_reset();
            bus.start     = ($urandom_range(0, 9) == 0);
            bus.step      = ($urandom_range(0, 14) == 0);
            bus.halt_req  = ($urandom_range(0, 19) == 0);
            bus.prog_we   = ($urandom_range(0, 3) == 0);
            bus.prog_addr = 3'($urandom_range(0, 7));
            bus.prog_data = 9'($urandom_range(0, 511));
            bus.carry_in  = 1'($urandom_range(0, 1));
            cyc();
        end
        idle_in();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
